// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: Q4.20 word format, angle constants, FSM and quadrant encodings.
package cordic_pkg;

  localparam int INTEGER_WIDTH    = 4;
  localparam int FRACTIONAL_WIDTH = 20;
  localparam int DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH;

  localparam logic [DATA_WIDTH-1:0] HALF_PI       = 24'd1647099;
  localparam logic [DATA_WIDTH-1:0] PI            = 24'd3294198;
  localparam logic [DATA_WIDTH-1:0] THREE_HALF_PI = 24'd4941297;
  localparam logic [DATA_WIDTH-1:0] TWO_PI        = 24'd6588396;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WRAP = 2'd1,
    QUAD = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    QUADRANT_0 = 2'd0,
    QUADRANT_1 = 2'd1,
    QUADRANT_2 = 2'd2,
    QUADRANT_3 = 2'd3
  } quad_t;

  // Start of quadrant q in Q4.20, i.e. q * pi/2.
  function automatic logic [DATA_WIDTH-1:0] quad_base(input logic [1:0] q);
    case (q)
      2'd0:    return '0;
      2'd1:    return HALF_PI;
      2'd2:    return PI;
      default: return THREE_HALF_PI;
    endcase
  endfunction

endpackage

// File: rtl/cordic_quadrant_sel.sv
// Maps a wrapped angle in [0, 2*pi) to its quadrant and first-quadrant residual.
module cordic_quadrant_sel
  import cordic_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] acc,
  output quad_t                 quadrant,
  output logic [DATA_WIDTH-1:0] residual
);

  // Thermometer of quadrant boundaries crossed; its population count is the quadrant.
  logic [2:0] at_or_above;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bound
      assign at_or_above[gi] = (acc >= quad_base(2'(gi + 1)));
    end
  endgenerate

  logic [1:0] quad_idx;

  always_comb begin
    quad_idx = 2'(at_or_above[0]) + 2'(at_or_above[1]) + 2'(at_or_above[2]);
    quadrant = quad_t'(quad_idx);
    residual = acc - quad_base(quad_idx);
  end

endmodule

// File: rtl/cordic_angle_reduce.sv
// Wraps a signed Q4.20 angle into [0, 2*pi) and splits it into quadrant plus [0, pi/2) residual.
module cordic_angle_reduce
  import cordic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] angle_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] angle_out,
  output logic [1:0]            quadrant,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic signed [DATA_WIDTH:0] TWO_PI_EXT = {1'b0, TWO_PI};

  state_t                       state_reg;
  state_t                       state_next;
  logic signed [DATA_WIDTH:0]   acc_reg;
  logic [DATA_WIDTH-1:0]        angle_reg;
  logic [1:0]                   quad_reg;

  quad_t                        sel_quadrant;
  logic [DATA_WIDTH-1:0]        sel_residual;

  logic accept;
  logic acc_negative;
  logic acc_too_big;

  assign accept       = in_valid && in_ready;
  assign acc_negative = (acc_reg < 0);
  assign acc_too_big  = (acc_reg >= TWO_PI_EXT);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = WRAP;
      WRAP:    if (!acc_negative && !acc_too_big) state_next = QUAD;
      QUAD:    state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; in_ready must stay low for the whole reset assertion.
  always_comb begin
    in_ready  = (state_reg == IDLE) && rst;
    out_valid = (state_reg == OUT);
  end

  // Datapath: accumulator walks into range one 2*pi step per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg   <= '0;
      angle_reg <= '0;
      quad_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) acc_reg <= {angle_in[DATA_WIDTH-1], angle_in};
        end
        WRAP: begin
          if (acc_negative) begin
            acc_reg <= acc_reg + TWO_PI_EXT;
          end else if (acc_too_big) begin
            acc_reg <= acc_reg - TWO_PI_EXT;
          end
        end
        QUAD: begin
          angle_reg <= sel_residual;
          quad_reg  <= sel_quadrant;
        end
        default: ;
      endcase
    end
  end

  cordic_quadrant_sel u_quadrant_sel (
    .acc      (acc_reg[DATA_WIDTH-1:0]),
    .quadrant (sel_quadrant),
    .residual (sel_residual)
  );

  assign angle_out = angle_reg;
  assign quadrant  = quad_reg;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Randomized and directed bench for cordic_angle_reduce against an arithmetic reference model.
module tb_cordic_angle_reduce;

  localparam int DW      = 24;
  localparam int HALF    = 1647099;
  localparam int FULL    = 4 * HALF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] angle_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] angle_out;
  logic [1:0]    quadrant;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cordic_angle_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .angle_in  (angle_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_out (angle_out),
    .quadrant  (quadrant),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Reference: wrap by whole turns, then integer-divide by pi/2.
  function automatic void model(input int a, output int n, output int q, output int r);
    n = 0;
    while (a < 0)     begin a += FULL; n++; end
    while (a >= FULL) begin a -= FULL; n++; end
    q = a / HALF;
    r = a % HALF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; hold cycles keep out_ready low after out_valid to probe stability.
  task automatic run_txn(input int a, input int hold);
    int n, q, r, cyc, bound;
    logic [DW-1:0] held_angle;
    logic [1:0]    held_quad;
    model(a, n, q, r);
    bound = 0;
    while (!in_ready && bound < 20) begin tick(); bound++; end
    check("in_ready_before_txn", in_ready, 1);
    out_ready = (hold == 0);
    angle_in  = DW'(a);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    check("in_ready_after_capture", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 10) begin tick(); cyc++; end
    check("latency", cyc, n + 2);
    check("quadrant", quadrant, q);
    check("angle_out", angle_out, r);
    check("in_ready_in_out", in_ready, 0);
    $display("txn angle=%0d n=%0d lat=%0d quadrant=%0d angle_out=%0d", a, n, cyc, quadrant, angle_out);
    held_angle = angle_out;
    held_quad  = quadrant;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_angle", angle_out, held_angle);
      check("hold_quad", quadrant, held_quad);
    end
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", out_valid, 0);
    check("in_ready_after_handshake", in_ready, 1);
    check("angle_retained", angle_out, r);
  endtask

  initial begin
    int dir [] = '{0, 2097152, 1647099, -8388608, 7340032, 6588396, 1647098,
                   3294198, 4941297, 8388607, -1, -6588396};
    logic [DW-1:0] raw;
    int q0, r0, n0;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_angle_out", angle_out, 0);
    check("rst_quadrant", quadrant, 0);
    rst = 1'b1;
    #1;
    check("in_ready_after_rst", in_ready, 1);

    foreach (dir[i]) run_txn(dir[i], 0);

    // Back-pressure with ignored in_valid pulses
    out_ready = 1'b0;
    angle_in  = DW'(2097152);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    begin
      int cyc = 0;
      while (!out_valid && cyc < 10) begin tick(); cyc++; end
      check("bp_latency", cyc, 2);
    end
    for (int i = 0; i < 5; i++) begin
      angle_in = DW'(1048576);
      in_valid = i[0];
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_quad", quadrant, 1);
      check("bp_angle", angle_out, 450053);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_drop", out_valid, 0);
    run_txn(1048576, 0);

    // Reset during WRAP
    angle_in = DW'(-8388608);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_angle", angle_out, 0);
    check("midrst_quad", quadrant, 0);
    check("midrst_in_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    #1;
    check("postrst_in_ready", in_ready, 1);
    run_txn(-8388608, 0);

    // Random angles over the full Q4.20 range
    for (int t = 0; t < 40; t++) begin
      raw = DW'($urandom);
      run_txn({{8{raw[DW-1]}}, raw}, $urandom_range(0, 3));
    end
    model(0, n0, q0, r0);
    check("model_sanity_zero", r0 + q0 + n0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", n_checks, -1);
    $fatal(1, "timeout");
  end

endmodule
